// File: rtl/branch_stall_unit.sv
// Pipeline stall control for load-use and branch-operand hazards.
// A load feeding a branch holds the pipe for two cycles via a one-cycle HOLD state.
module branch_stall_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [4:0]  ifidrs,
  input  logic [4:0]  ifidrt,
  input  logic [4:0]  idexrd,
  input  logic        idexregwrite,
  input  logic        idexmemread,
  input  logic [4:0]  exmemrd,
  input  logic        exmemmemread,
  input  logic        flush,
  output logic        stall,
  output logic        pcwrite,
  output logic        ifidwrite,
  output logic [1:0]  state,
  output logic [15:0] stallcycles,
  output logic [15:0] loadbranchcnt
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] HOLD = 2'b01;

  logic       is_branch;
  logic       uses_rt;
  logic       match_ex;
  logic       match_mem;
  logic       h1;
  logic       h2;
  logic       in_hold;
  logic       enter_hold;
  logic [1:0] next_state;

  assign is_branch = (op == 6'h04) || (op == 6'h05);
  assign uses_rt   = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);

  // Register 0 is hardwired, so it never carries a real dependency.
  assign match_ex  = (idexrd != 5'd0) &&
                     ((idexrd == ifidrs) || (uses_rt && (idexrd == ifidrt)));
  assign match_mem = (exmemrd != 5'd0) &&
                     ((exmemrd == ifidrs) || (uses_rt && (exmemrd == ifidrt)));

  assign h2 = is_branch && idexmemread && match_ex;
  assign h1 = !h2 && ((!is_branch && idexmemread && match_ex) ||
                      (is_branch && idexregwrite && !idexmemread && match_ex) ||
                      (is_branch && exmemmemread && match_mem));

  // Reset makes the block behave as IDLE immediately, cancelling a pending second stall.
  assign in_hold    = (state == HOLD) && !reset;
  assign enter_hold = (state == IDLE) && h2 && !flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    stall      = 1'b0;
    next_state = IDLE;
    if (in_hold) begin
      stall = !flush;
    end else begin
      stall = (h1 || h2) && !flush;
      if (enter_hold) next_state = HOLD;
    end
  end

  assign pcwrite   = ~stall;
  assign ifidwrite = ~stall;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state         <= IDLE;
      stallcycles   <= 16'd0;
      loadbranchcnt <= 16'd0;
    end else begin
      state <= next_state;
      if (stall && (stallcycles != 16'hFFFF))
        stallcycles <= stallcycles + 16'd1;
      if (enter_hold && (loadbranchcnt != 16'hFFFF))
        loadbranchcnt <= loadbranchcnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_stall_unit.sv
// Bench for branch_stall_unit: directed scenarios plus randomized traffic
// compared against a behavioural model built from source-register sets.
module tb_branch_stall_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic [4:0]  ifidrs, ifidrt, idexrd, exmemrd;
  logic        idexregwrite, idexmemread, exmemmemread, flush;
  logic        stall, pcwrite, ifidwrite;
  logic [1:0]  state;
  logic [15:0] stallcycles, loadbranchcnt;

  int checks = 0;
  int errors = 0;

  // Model state: whether a second load-to-branch stall cycle is owed, and counters.
  bit m_pending;
  int m_sc, m_lb;
  bit n_pending;
  int n_sc, n_lb;
  logic        exp_stall;
  logic [1:0]  exp_state;
  logic [15:0] exp_sc, exp_lb;

  always #5 clock = ~clock;

  branch_stall_unit dut (
    .clock(clock), .reset(reset), .op(op), .ifidrs(ifidrs), .ifidrt(ifidrt),
    .idexrd(idexrd), .idexregwrite(idexregwrite), .idexmemread(idexmemread),
    .exmemrd(exmemrd), .exmemmemread(exmemmemread), .flush(flush),
    .stall(stall), .pcwrite(pcwrite), .ifidwrite(ifidwrite), .state(state),
    .stallcycles(stallcycles), .loadbranchcnt(loadbranchcnt)
  );

  // True when instruction o reads register d (d nonzero).
  function automatic bit reads_reg(logic [5:0] o, logic [4:0] rs, logic [4:0] rt, logic [4:0] d);
    logic [4:0] srcs[$];
    srcs.push_back(rs);
    if (o inside {6'h00, 6'h04, 6'h05, 6'h2B}) srcs.push_back(rt);
    if (d == 5'd0) return 1'b0;
    foreach (srcs[i]) if (srcs[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, wait to the falling edge and compute model expectations.
  task automatic drive(input logic [5:0] o, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] drd, input logic rw, input logic mr,
                       input logic [4:0] mrd, input logic mmr, input logic fl, input logic rst);
    bit br, dep_ex, dep_mem, two, one, any;
    op = o; ifidrs = rs; ifidrt = rt; idexrd = drd; idexregwrite = rw; idexmemread = mr;
    exmemrd = mrd; exmemmemread = mmr; flush = fl; reset = rst;
    @(negedge clock);
    br      = (o == 6'h04) || (o == 6'h05);
    dep_ex  = reads_reg(o, rs, rt, drd);
    dep_mem = reads_reg(o, rs, rt, mrd);
    two = br && mr && dep_ex;
    one = !two && ((!br && mr && dep_ex) || (br && rw && !mr && dep_ex) || (br && mmr && dep_mem));
    any = one || two;
    if (fl)                     exp_stall = 1'b0;
    else if (m_pending && !rst) exp_stall = 1'b1;
    else                        exp_stall = any;
    exp_state = m_pending ? 2'b01 : 2'b00;
    exp_sc    = 16'(m_sc);
    exp_lb    = 16'(m_lb);
    if (rst) begin
      n_pending = 1'b0; n_sc = 0; n_lb = 0;
    end else begin
      n_sc = (exp_stall && m_sc < 65535) ? m_sc + 1 : m_sc;
      n_lb = m_lb;
      n_pending = 1'b0;
      if (!m_pending && two && !fl) begin
        n_pending = 1'b1;
        if (m_lb < 65535) n_lb = m_lb + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    m_pending = n_pending; m_sc = n_sc; m_lb = n_lb;
  endtask

  task automatic idle_cycle(input logic rst);
    drive(6'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, rst);
  endtask

  task automatic apply_reset();
    idle_cycle(1'b1);
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    idle_cycle(1'b0);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state: got %b want 00", state); end
    checks++; if (stallcycles !== 16'd0) begin errors++; $display("FAIL rst_sc: got %h want 0000", stallcycles); end
    checks++; if (loadbranchcnt !== 16'd0) begin errors++; $display("FAIL rst_lb: got %h want 0000", loadbranchcnt); end
    checks++; if ({stall, pcwrite, ifidwrite} !== 3'b011) begin errors++; $display("FAIL rst_stall: got %b want 011", {stall, pcwrite, ifidwrite}); end
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(6'h00, 5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if ({stall, pcwrite} !== 2'b10) begin errors++; $display("FAIL lu_stall: got %b want 10", {stall, pcwrite}); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL lu_state: got %b want 00", state); end
    tick();
    idle_cycle(1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_after: got %b want 0", stall); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL lu_state2: got %b want 00", state); end
    checks++; if (stallcycles !== 16'd1) begin errors++; $display("FAIL lu_sc: got %0d want 1", stallcycles); end
    tick();
  endtask

  task automatic test_load_branch();
    apply_reset();
    drive(6'h04, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if ({stall, state} !== 3'b100) begin errors++; $display("FAIL lb_c1: got %b want 100", {stall, state}); end
    tick();
    idle_cycle(1'b0);
    checks++; if ({stall, state} !== 3'b101) begin errors++; $display("FAIL lb_c2: got %b want 101", {stall, state}); end
    tick();
    idle_cycle(1'b0);
    checks++; if ({stall, state} !== 3'b000) begin errors++; $display("FAIL lb_c3: got %b want 000", {stall, state}); end
    checks++; if (loadbranchcnt !== 16'd1) begin errors++; $display("FAIL lb_cnt: got %0d want 1", loadbranchcnt); end
    checks++; if (stallcycles !== 16'd2) begin errors++; $display("FAIL lb_sc: got %0d want 2", stallcycles); end
    tick();
  endtask

  task automatic test_alu_branch();
    apply_reset();
    drive(6'h05, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ab_stall: got %b want 1", stall); end
    tick();
    drive(6'h05, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if ({stall, state} !== 3'b000) begin errors++; $display("FAIL ab_zero: got %b want 000", {stall, state}); end
    checks++; if (stallcycles !== 16'd1) begin errors++; $display("FAIL ab_sc: got %0d want 1", stallcycles); end
    tick();
  endtask

  task automatic test_flush_in_hold();
    apply_reset();
    drive(6'h04, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(6'h04, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    checks++; if ({stall, state} !== 3'b001) begin errors++; $display("FAIL fl_hold: got %b want 001", {stall, state}); end
    tick();
    idle_cycle(1'b0);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL fl_state: got %b want 00", state); end
    checks++; if (stallcycles !== 16'd1) begin errors++; $display("FAIL fl_sc: got %0d want 1", stallcycles); end
    tick();
  endtask

  task automatic test_reset_in_hold();
    apply_reset();
    drive(6'h05, 5'd2, 5'd6, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_cycle(1'b1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rh_stall: got %b want 0", stall); end
    tick();
    idle_cycle(1'b0);
    checks++; if ({state, stallcycles, loadbranchcnt} !== 34'd0) begin
      errors++; $display("FAIL rh_clear: got state=%b sc=%0d lb=%0d want 0/0/0", state, stallcycles, loadbranchcnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] ops [6] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      drive(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
      checks++;
      if ({stall, pcwrite, ifidwrite, state} !== {exp_stall, ~exp_stall, ~exp_stall, exp_state}) begin
        errors++; $display("FAIL rnd_ctl[%0d]: got stall=%b pw=%b iw=%b st=%b want stall=%b st=%b",
                           i, stall, pcwrite, ifidwrite, state, exp_stall, exp_state);
      end
      checks++;
      if ({stallcycles, loadbranchcnt} !== {exp_sc, exp_lb}) begin
        errors++; $display("FAIL rnd_cnt[%0d]: got sc=%0d lb=%0d want sc=%0d lb=%0d",
                           i, stallcycles, loadbranchcnt, exp_sc, exp_lb);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 65534; i++) begin
      drive(6'h00, 5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(6'h00, 5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (stallcycles !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", stallcycles); end
    tick();
    drive(6'h00, 5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(6'h00, 5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (stallcycles !== 16'hFFFF) begin errors++; $display("FAIL sat_top: got %h want ffff", stallcycles); end
    tick();
    idle_cycle(1'b0);
    checks++; if (stallcycles !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", stallcycles); end
    tick();
  endtask

  initial begin
    m_pending = 1'b0; m_sc = 0; m_lb = 0;
    reset = 1'b1; flush = 1'b0; op = '0; ifidrs = '0; ifidrt = '0; idexrd = '0;
    idexregwrite = 1'b0; idexmemread = 1'b0; exmemrd = '0; exmemmemread = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_flush_in_hold();
    test_reset_in_hold();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
